shift_add_mul_8bit: RTL and testbench

SHIFT_ADD_MUL_8BIT -- requirements
Module: shift_add_mul_8bit

---
 rtl/shift_add_mul_8bit_pkg.sv | 20 ++
 rtl/shift_add_mul_8bit_adder.sv | 27 ++
 rtl/shift_add_mul_8bit.sv | 113 +++++++++++
 tb/tb_shift_add_mul_8bit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_8bit_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding,
// default operand width and iteration-counter sizing.
package shift_add_mul_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_mul_8bit_adder.sv
// Ripple-carry adder built from a chain of single-bit full adders.
module shift_add_mul_8bit_adder
    import shift_add_mul_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mul_8bit.sv
// Sequential unsigned multiplier: one shift-and-add step per cycle,
// result registered on p with a single-cycle done pulse.
module shift_add_mul_8bit
    import shift_add_mul_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = cnt_width(WIDTH);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q;

    logic            load;
    logic            step;
    logic            capture;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;

    // Control: state, iteration counter and the registered done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= (state_q == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                end
            end
            RUN: begin
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = (state_q == IDLE) && start;
        step    = (state_q == RUN);
        capture = (state_q == DONE);
        busy    = step;
        done    = done_q;
    end

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    shift_add_mul_8bit_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_hi_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Datapath: the carry-out becomes the new MSB so no product bit is lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            p_q      <= '0;
        end else begin
            if (load) begin
                mcand_q  <= x;
                acc_hi_q <= '0;
                acc_lo_q <= y;
            end else if (step) begin
                {acc_hi_q, acc_lo_q} <= {cout, sum, acc_lo_q[WIDTH-1:1]};
            end
            if (capture) begin
                p_q <= {acc_hi_q, acc_lo_q};
            end
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_shift_add_mul_8bit.sv
// Scoreboard bench for shift_add_mul_8bit: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_shift_add_mul_8bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_checks = 0;
    int n_fails  = 0;
    int done_count = 0;
    bit prev_done = 1'b0;
    logic [15:0] sb[$];

    shift_add_mul_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: mutual exclusion every cycle, result check on every done
    always @(negedge clk) begin
        logic [15:0] e;
        check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) begin
            done_count++;
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("p_scoreboard", {16'd0, p}, {16'd0, e});
                $display("result p=%0d expected=%0d", p, e);
            end
        end
        prev_done = (done === 1'b1);
    end

    // One multiply: accept, then measure busy cycles and latency to done
    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        int lat;
        int busy_n;
        bit seen;
        start = 1'b1;
        x = a;
        y = b;
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        sb.push_back({8'd0, a} * {8'd0, b});
        lat = 1;
        busy_n = busy ? 1 : 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) busy_n++;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, 10);
        check("busy_cycles", busy_n, 8);
    endtask

    initial begin
        int d_cnt;
        int last_done;
        int dc0;
        rst_n = 1'b0;
        start = 1'b1;
        x = 8'd55;
        y = 8'd77;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_p", {16'd0, p}, 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start_during_reset_ignored", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);

        run_op(8'd13, 8'd11);
        run_op(8'd255, 8'd255);
        run_op(8'd0, 8'd200);
        run_op(8'd200, 8'd0);
        repeat (3) @(negedge clk);
        check("p_hold_idle", {16'd0, p}, 32'd0);

        // start held high: accepted only in IDLE, one result every 10 cycles
        dc0 = done_count;
        repeat (3) sb.push_back(16'd42);
        start = 1'b1;
        x = 8'd6;
        y = 8'd7;
        d_cnt = 0;
        last_done = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) check("held_accept_busy", {31'd0, busy}, 32'd1);
            if (i == 3) x = 8'd9;
            if (i == 6) x = 8'd6;
            if (done === 1'b1) begin
                d_cnt++;
                check("held_done_spacing", i, 10 * d_cnt);
                last_done = i;
            end
            if (i == 30) start = 1'b0;
        end
        check("held_done_count", d_cnt, 3);
        check("held_last_done", last_done, 30);
        repeat (12) @(negedge clk);
        check("held_total_dones", done_count - dc0, 3);

        // reset mid-RUN aborts with no done pulse
        dc0 = done_count;
        start = 1'b1;
        x = 8'd100;
        y = 8'd3;
        @(negedge clk);
        start = 1'b0;
        check("abort_accept_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_p", {16'd0, p}, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", done_count - dc0, 0);
        run_op(8'd100, 8'd3);

        // random operands, back-to-back
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        repeat (15) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
